// File: rtl/boltzmann_sampler.sv
// rtl/boltzmann_sampler.sv - collects node on-count and neighbour co-activation counts, streams them out
module boltzmann_sampler #(
    parameter int COUNT_W       = 16,
    parameter int BURN_IN       = 16,
    parameter int NUM_SAMPLES   = 256,
    parameter int SAMPLE_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               node,
    input  logic [3:0]         neighbours,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_index,
    output logic [COUNT_W-1:0] out_data,
    output logic               out_last,
    output logic               done
);

    localparam int BW = (BURN_IN > 1) ? $clog2(BURN_IN) : 1;
    localparam int NW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int SW = (SAMPLE_STRIDE > 1) ? $clog2(SAMPLE_STRIDE) : 1;

    localparam logic [BW-1:0]      BURN_LAST   = BW'((BURN_IN > 0) ? BURN_IN - 1 : 0);
    localparam logic [NW-1:0]      SAMPLE_LAST = NW'(NUM_SAMPLES - 1);
    localparam logic [SW-1:0]      STRIDE_LAST = SW'(SAMPLE_STRIDE - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURN,
        S_SAMPLE,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BW-1:0]      r_burn;
    logic [NW-1:0]      r_nsamp;
    logic [SW-1:0]      r_stride;
    logic [2:0]         r_idx;
    logic               r_done;
    logic [COUNT_W-1:0] r_cnt [5];

    logic               w_take;
    logic               w_last_sample;
    logic               w_hs;
    logic               w_last_word;
    logic [4:0]         w_hit;

    // bit 0 is the node itself, bit i+1 is node & neighbours[i]
    assign w_hit         = {{4{node}} & neighbours, node};
    assign w_take        = (r_state == S_SAMPLE) && (r_stride == '0);
    assign w_last_sample = w_take && (r_nsamp == SAMPLE_LAST);
    assign w_hs          = out_valid && out_ready;
    assign w_last_word   = w_hs && (r_idx == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (BURN_IN == 0) ? S_SAMPLE : S_BURN;
                end
            end
            S_BURN: begin
                if (r_burn == BURN_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_last_sample) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_word) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burn   <= '0;
            r_nsamp  <= '0;
            r_stride <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_done <= w_last_word;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_burn   <= '0;
                        r_nsamp  <= '0;
                        r_stride <= '0;
                        r_idx    <= '0;
                        for (int i = 0; i < 5; i++) begin
                            r_cnt[i] <= '0;
                        end
                    end
                end
                S_BURN: begin
                    r_burn <= r_burn + 1'b1;
                end
                S_SAMPLE: begin
                    r_stride <= (r_stride == STRIDE_LAST) ? '0 : r_stride + 1'b1;
                    if (w_take) begin
                        r_nsamp <= r_nsamp + 1'b1;
                        // saturate rather than wrap so long runs still give a usable upper bound
                        for (int i = 0; i < 5; i++) begin
                            if (w_hit[i] && (r_cnt[i] != CNT_MAX)) begin
                                r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        r_idx <= w_last_word ? 3'd0 : r_idx + 3'd1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DRAIN);
        out_index = out_valid ? r_idx : 3'd0;
        out_last  = out_valid && (r_idx == 3'd4);
        done      = r_done;
        out_data  = '0;
        if (out_valid) begin
            case (r_idx)
                3'd0:    out_data = r_cnt[0];
                3'd1:    out_data = r_cnt[1];
                3'd2:    out_data = r_cnt[2];
                3'd3:    out_data = r_cnt[3];
                3'd4:    out_data = r_cnt[4];
                default: out_data = '0;
            endcase
        end
    end

endmodule
